// File: rtl/mux_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_arb_pkg : shared sizes and state encoding for mux4_rr_arbiter    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mux_arb_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage : mux_arb_pkg
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick4 : rotating-priority search over 4 requests starting at ptr  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset back to ptr so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux4_rr_arbiter : round-robin owner of a shared 4:1 data mux         |
// | Optional hold timeout compiled in with MUXARB_TIMEOUT_EN.  Rev 1.0   |
// +----------------------------------------------------------------------+
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        last,
  input  logic [NREQ*DATA_W-1:0] data_in,
  output logic [NREQ-1:0]        gnt,
  output logic [SEL_W-1:0]       sel,
  output logic [DATA_W-1:0]      data_out,
  output logic                   valid_out,
  output logic                   timeout
);

  generate
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
      $error("mux4_rr_arbiter: HOLD_MAX must be within 1..255");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              release_w;
  logic              found_w;
  logic [SEL_W-1:0]  idx_w;
`ifdef MUXARB_TIMEOUT_EN
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
`endif

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (found_w),
    .idx   (idx_w)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    release_w = 1'b0;
`ifdef MUXARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found_w) begin
          state_d        = ST_BUSY;
          gnt_d          = '0;
          gnt_d[idx_w]   = 1'b1;
          sel_d          = idx_w;
`ifdef MUXARB_TIMEOUT_EN
          cnt_d          = '0;
`endif
        end
      end
      ST_BUSY: begin
        data_d    = data_in[sel_q*DATA_W +: DATA_W];
        valid_d   = req[sel_q];
        release_w = !req[sel_q] || last[sel_q];
`ifdef MUXARB_TIMEOUT_EN
        // Forced release only when the owner did not finish on its own this cycle.
        cnt_d = cnt_q + CNT_W'(1);
        if (!release_w && cnt_d == CNT_W'(HOLD_MAX)) begin
          release_w = 1'b1;
          timeout_d = 1'b1;
        end
`endif
        if (release_w) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + SEL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
`ifdef MUXARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
`ifdef MUXARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
`ifdef MUXARB_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule : mux4_rr_arbiter
`default_nettype wire
